// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: FSM state encodings shared by the serial subtractor files.
package serial_subtractor_pkg;
  localparam logic [1:0] SS_IDLE = 2'd0;
  localparam logic [1:0] SS_RUN  = 2'd1;
  localparam logic [1:0] SS_DONE = 2'd2;
endpackage

// File: rtl/serial_subtractor_full_subtractor1.sv
// full_subtractor1: one-bit combinational subtractor cell, d = a - b - bin.
module full_subtractor1 (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, valid/ready request and response.
// Defining SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] d,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             bout
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [WIDTH-1:0] a_q, b_q, d_q;
  logic br_q, bout_q, diff, br_nxt, last;
  full_subtractor1 u_cell (.a(a_q[0]), .b(b_q[0]), .bin(br_q), .d(diff), .bout(br_nxt));
  assign last = cnt_q == LAST;
  always_comb begin
    state_d = state_q == SS_IDLE ? (req_valid ? SS_RUN : SS_IDLE)
            : state_q == SS_RUN  ? (last ? SS_DONE : SS_RUN)
            : state_q == SS_DONE ? (rsp_ready ? SS_IDLE : SS_DONE)
            : SS_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SS_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == SS_IDLE && req_valid) begin
        a_q   <= a;
        b_q   <= b;
        br_q  <= bin;
        cnt_q <= '0;
      end else if (state_q == SS_RUN) begin
        d_q   <= {diff, d_q[WIDTH-1:1]};
        a_q   <= a_q >> 1;
        b_q   <= b_q >> 1;
        br_q  <= br_nxt;
        cnt_q <= cnt_q + CW'(1);
        if (last) bout_q <= br_nxt;
      end
    end
  end
`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_q, b_msb_q, ovf_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state_q == SS_IDLE && req_valid) begin
      a_msb_q <= a[WIDTH-1];
      b_msb_q <= b[WIDTH-1];
    end else if (state_q == SS_RUN && last) begin
      ovf_q <= (a_msb_q ^ b_msb_q) & (a_msb_q ^ diff);
    end
  end
  assign ovf = ovf_q;
`endif
  assign req_ready = state_q == SS_IDLE;
  assign rsp_valid = state_q == SS_DONE;
  assign d         = d_q;
  assign bout      = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor against an arithmetic model.
module tb_serial_subtractor;
  localparam int W = 4;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, bin = 1'b0, rsp_ready = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic req_ready, rsp_valid, bout;
  logic [W-1:0] d;
  logic ovf_o;
  int tests = 0, fails = 0;
  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .a(a), .b(b), .bin(bin), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .d(d),
`ifdef SERIAL_SUB_OVF_EN
    .ovf(ovf_o),
`endif
    .bout(bout)
  );
`ifndef SERIAL_SUB_OVF_EN
  assign ovf_o = 1'b0;
`endif
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] ea, input logic [W-1:0] eb, input logic ebin, input int stall);
    logic [W-1:0] exp_d;
    logic exp_bout, exp_ovf;
    int k;
    exp_d    = W'(int'(ea) - int'(eb) - int'(ebin));
    exp_bout = int'(ea) < int'(eb) + int'(ebin);
    exp_ovf  = (ea[W-1] ^ eb[W-1]) & (ea[W-1] ^ exp_d[W-1]);
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    a = ea; b = eb; bin = ebin; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    chk("run_req_ready", 32'(req_ready), 32'd0);
    k = 1;
    while (!rsp_valid && k < 20) begin
      tick();
      if (!rsp_valid) k++;
    end
    chk("latency", 32'(k), 32'(W));
    chk("d", 32'(d), 32'(exp_d));
    chk("bout", 32'(bout), 32'(exp_bout));
`ifdef SERIAL_SUB_OVF_EN
    chk("ovf", 32'(ovf_o), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) chk("ovf_model", 32'(exp_ovf), 32'd0);
`endif
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1;
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      tick();
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      chk("stall_d", 32'(d), 32'(exp_d));
      chk("stall_bout", 32'(bout), 32'(exp_bout));
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_req_ready", 32'(req_ready), 32'd1);
    chk("post_d_kept", 32'(d), 32'(exp_d));
  endtask

  initial begin
    tick();
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    chk("rst_ovf", 32'(ovf_o), 32'd0);
    rst = 1'b0;
    tick();
    run_op(4'b0001, 4'b0001, 1'b0, 0);
    run_op(4'b0001, 4'b0011, 1'b0, 0);
    run_op(4'b1000, 4'b0111, 1'b0, 0);
    run_op(4'b0000, 4'b1111, 1'b1, 0);
    run_op(4'b0110, 4'b1010, 1'b0, 5);
    a = 4'b0101; b = 4'b0001; bin = 1'b0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrun_rst_req_ready", 32'(req_ready), 32'd1);
    chk("midrun_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrun_rst_d", 32'(d), 32'd0);
    run_op(4'b0011, 4'b0001, 1'b0, 0);
    for (int n = 0; n < 20; n++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
